// File: rtl/wb_soc_ctrl_pkg.sv
// Shared constants and types for the Wishbone SoC control block: register map,
// CTRL bit positions, reset values and a byte-lane merge helper.
package soc_ctrl_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = WB_DW / 8;
  localparam int unsigned OFF_W = 6;

  // Word offsets taken from adr[7:2]
  localparam logic [OFF_W-1:0] OFF_CTRL    = 6'h00;
  localparam logic [OFF_W-1:0] OFF_BAUD    = 6'h01;
  localparam logic [OFF_W-1:0] OFF_STATUS  = 6'h02;
  localparam logic [OFF_W-1:0] OFF_SCRATCH = 6'h03;

  localparam int unsigned CTRL_HOLD_RST  = 0;
  localparam int unsigned CTRL_PROG_SW   = 1;
  localparam int unsigned CTRL_PROG_SEL  = 2;
  localparam int unsigned CTRL_RST_PULSE = 3;

  localparam logic        RST_HOLD_RST  = 1'b1;
  localparam logic        RST_PROG_SW   = 1'b0;
  localparam logic        RST_PROG_SEL  = 1'b0;
  localparam logic [31:0] RST_SCRATCH   = 32'h0;
  localparam logic [7:0]  RST_PRESS_CNT = 8'h0;
  localparam logic [7:0]  RST_PULSE_CNT = 8'h0;

  typedef struct packed {
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
  } wb_req_t;

  // Replace only the byte lanes enabled in sel
  function automatic logic [WB_DW-1:0] merge_bytes(input logic [WB_DW-1:0] cur,
                                                   input logic [WB_DW-1:0] wr,
                                                   input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] res;
    res = cur;
    for (int i = 0; i < int'(WB_SW); i++) begin
      if (sel[i]) res[8*i +: 8] = wr[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_soc_ctrl_prog_debounce.sv
// Two-flop synchroniser plus debouncer for the program button; rise_o pulses
// in the same cycle db_o goes high.
module prog_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic db_o,
  output logic rise_o
);

  localparam int unsigned CNT_W = 16;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_o   <= 1'b0;
      rise_o <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= pin_i;
      sync2  <= sync1;
      rise_o <= 1'b0;
      // Accept the new level on the Nth consecutive differing cycle
      if (sync2 != db_o) begin
        if (cnt >= DEBOUNCE_CYCLES - CNT_W'(1)) begin
          db_o   <= sync2;
          rise_o <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/wb_soc_ctrl.sv
// Wishbone slave controlling SoC reset, program select and UART baud divisor,
// with a debounced program button and press counter.
module wb_soc_ctrl
  import soc_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
  parameter logic [15:0] DEFAULT_CPB      = 16'd868,
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd1000,
  parameter logic [7:0]  RST_PULSE_CYCLES = 8'd16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        prog_pin_i,
  output logic        prog_o,
  output logic        soc_rst_no,
  output logic [15:0] clks_per_bit_o
);

  wb_req_t          req_c;
  logic             hit_c;
  logic             take_c;
  logic             wr_c;
  logic [OFF_W-1:0] off_c;
  logic [31:0]      rdata_c;
  logic [31:0]      cpb_merged_c;
  logic             unused_c;

  logic        hold_rst;
  logic        prog_sw;
  logic        prog_sel;
  logic [15:0] cpb;
  logic [31:0] scratch;
  logic [7:0]  press_cnt;
  logic [7:0]  pulse_cnt;
  logic        prog_db;
  logic        prog_rise;

  prog_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .pin_i (prog_pin_i),
    .db_o  (prog_db),
    .rise_o(prog_rise)
  );

  assign req_c    = '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};
  assign unused_c = ^{req_c.adr[1:0]};
  assign hit_c    = wbs_cyc_i & wbs_stb_i & (req_c.adr[31:8] == BASE_ADDR[31:8]);
  // Blocking the cycle right after an ack gives held requests every-other-cycle acks
  assign take_c   = hit_c & ~wbs_ack_o;
  assign wr_c     = take_c & req_c.we;
  assign off_c    = req_c.adr[7:2];
  assign cpb_merged_c = merge_bytes({16'h0, cpb}, req_c.dat, req_c.sel);

  always_comb begin
    rdata_c = '0;
    case (off_c)
      OFF_CTRL:    rdata_c = {29'h0, prog_sel, prog_sw, hold_rst};
      OFF_BAUD:    rdata_c = {16'h0, cpb};
      OFF_STATUS:  rdata_c = {16'h0, press_cnt, 6'h0, ~soc_rst_no, prog_db};
      OFF_SCRATCH: rdata_c = scratch;
      default:     rdata_c = '0;
    endcase
  end

  // Bus handshake and register file
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      hold_rst  <= RST_HOLD_RST;
      prog_sw   <= RST_PROG_SW;
      prog_sel  <= RST_PROG_SEL;
      cpb       <= DEFAULT_CPB;
      scratch   <= RST_SCRATCH;
    end else begin
      wbs_ack_o <= take_c;
      wbs_dat_o <= (take_c && !req_c.we) ? rdata_c : '0;
      if (wr_c) begin
        case (off_c)
          OFF_CTRL: begin
            if (req_c.sel[0]) begin
              hold_rst <= req_c.dat[CTRL_HOLD_RST];
              prog_sw  <= req_c.dat[CTRL_PROG_SW];
              prog_sel <= req_c.dat[CTRL_PROG_SEL];
            end
          end
          OFF_BAUD:    cpb     <= cpb_merged_c[15:0];
          OFF_SCRATCH: scratch <= merge_bytes(scratch, req_c.dat, req_c.sel);
          default: ;
        endcase
      end
    end
  end

  // Soft reset pulse, press counter and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pulse_cnt      <= RST_PULSE_CNT;
      press_cnt      <= RST_PRESS_CNT;
      soc_rst_no     <= 1'b0;
      prog_o         <= 1'b0;
      clks_per_bit_o <= DEFAULT_CPB;
    end else begin
      if (wr_c && off_c == OFF_CTRL && req_c.sel[0] && req_c.dat[CTRL_RST_PULSE]) begin
        pulse_cnt <= RST_PULSE_CYCLES;
      end else if (pulse_cnt != 8'h0) begin
        pulse_cnt <= pulse_cnt - 8'd1;
      end
      if (prog_rise) press_cnt <= press_cnt + 8'd1;
      soc_rst_no     <= ~(hold_rst | (pulse_cnt != 8'h0));
      prog_o         <= prog_sel ? prog_sw : prog_db;
      clks_per_bit_o <= cpb;
    end
  end

endmodule

// File: tb/tb_wb_soc_ctrl.sv
// Directed bench for wb_soc_ctrl: bus timing, register map, soft reset pulse,
// button debounce and program select.
module tb_wb_soc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic        pin;
  logic        prog;
  logic        soc_rst_n;
  logic [15:0] cpb_o;

  int total = 0;
  int bad   = 0;

  wb_soc_ctrl dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat_w),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat_r),
    .prog_pin_i    (pin),
    .prog_o        (prog),
    .soc_rst_no    (soc_rst_n),
    .clks_per_bit_o(cpb_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One Wishbone access; lat is the ack latency in cycles, 0 if none within max_wait
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int max_wait,
                      output logic [31:0] rdata, output int lat);
    lat   = 0;
    rdata = 32'hdead_beef;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int i = 1; i <= max_wait; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat   = i;
        rdata = dat_r;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  int          lat;
  int          lows;
  int          first_hi;
  int          rises;
  logic        prev;
  int          acks;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_w = 32'h0; pin = 1'b0;
    wait_cycles(3);

    // Reset state
    check("rst_soc_rst_no", 32'(soc_rst_n), 32'h0);
    check("rst_cpb",        32'(cpb_o),     32'd868);
    check("rst_ack",        32'(ack),       32'h0);
    check("rst_dat",        dat_r,          32'h0);
    check("rst_prog",       32'(prog),      32'h0);
    rst = 1'b0;
    wait_cycles(2);
    check("rel_soc_rst_no", 32'(soc_rst_n), 32'h0);

    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 4, rd, lat);
    check("baud_rd",     rd,  32'h0000_0364);
    check("baud_rd_lat", lat, 32'd1);
    wait_cycles(1);
    check("dat_idle_zero", dat_r, 32'h0);

    // Release hold, then fire a soft reset pulse
    xfer(1'b1, 32'h3000_0000, 32'h0, 4'hF, 4, rd, lat);
    check("ctrl_wr_lat", lat, 32'd1);
    wait_cycles(2);
    check("hold_released", 32'(soc_rst_n), 32'h1);
    xfer(1'b1, 32'h3000_0000, 32'h8, 4'hF, 4, rd, lat);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!soc_rst_n) lows++;
    end
    check("pulse_len",  lows,            32'd16);
    check("pulse_done", 32'(soc_rst_n),  32'h1);
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4, rd, lat);
    check("ctrl_rd", rd, 32'h0);

    // 500-cycle glitch then a 1200-cycle high level
    rises = 0; prev = prog; first_hi = 0;
    pin = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (prog && !prev) rises++;
      prev = prog;
    end
    pin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (prog && !prev) rises++;
      prev = prog;
    end
    check("glitch_ignored", rises, 32'd0);
    pin = 1'b1;
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk); #1;
      if (prog && !prev) begin
        rises++;
        if (first_hi == 0) first_hi = i;
      end
      prev = prog;
    end
    check("db_rises",   rises,    32'd1);
    check("db_latency", first_hi, 32'd1003);
    xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 4, rd, lat);
    check("status_rd", rd, 32'h0000_0101);

    // Byte-lane write to BAUD
    xfer(1'b1, 32'h3000_0004, 32'hFFFF_1234, 4'b0001, 4, rd, lat);
    check("cpb_ack_cycle_old", 32'(cpb_o), 32'h0364);
    wait_cycles(1);
    check("cpb_next_cycle", 32'(cpb_o), 32'h0334);
    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 4, rd, lat);
    check("baud_sel_rd", rd, 32'h0000_0334);

    xfer(1'b1, 32'h3000_000C, 32'hAABB_CCDD, 4'b1100, 4, rd, lat);
    xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 4, rd, lat);
    check("scratch_sel", rd, 32'hAABB_0000);

    // Write to STATUS is ignored
    xfer(1'b1, 32'h3000_0008, 32'hFFFF_FFFF, 4'hF, 4, rd, lat);
    check("status_wr_ack", lat, 32'd1);
    xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 4, rd, lat);
    check("status_ro", rd, 32'h0000_0101);

    // Unmapped offset and foreign address
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 4, rd, lat);
    check("unmapped_rd",  rd,  32'h0);
    check("unmapped_lat", lat, 32'd1);
    xfer(1'b0, 32'h3100_0004, 32'h0, 4'hF, 6, rd, lat);
    check("foreign_no_ack", lat, 32'd0);

    // Held request is acked every other cycle
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_000C; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_acks", acks, 32'd3);

    // Program select with the button released and settled
    pin = 1'b0;
    wait_cycles(1100);
    xfer(1'b1, 32'h3000_0000, 32'h6, 4'hF, 4, rd, lat);
    wait_cycles(2);
    check("prog_sw_sel", 32'(prog), 32'h1);
    xfer(1'b1, 32'h3000_0000, 32'h2, 4'hF, 4, rd, lat);
    wait_cycles(2);
    check("prog_db_sel", 32'(prog), 32'h0);

    // Reset arriving with a request in flight
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_000C; dat_w = 32'h1234_5678; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_ack", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 4, rd, lat);
    check("rst_mid_scratch", rd, 32'h0);
    check("rst_mid_cpb", 32'(cpb_o), 32'd868);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
